// File: rtl/fpmu_pkg.sv
// rtl/fpmu_pkg.sv - FP16 field constants, encodings, state and operand-class types.
package fpmu_pkg;
   localparam int EXP_W  = 5;
   localparam int MANT_W = 11;
   localparam int BIAS   = 15;
   localparam int FRAC_W = MANT_W - 1;
   localparam int ACC_W  = 2 * MANT_W;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_INF  = 16'h7C00;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_CHECK,
      ST_MUL,
      ST_NORM,
      ST_OUT_HI,
      ST_OUT_LO
   } state_t;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_NAN
   } op_class_t;

   // Subnormals are flushed, so a zero exponent field always classifies as zero.
   function automatic op_class_t classify(input logic [15:0] v);
      if (v[FRAC_W +: EXP_W] == '0)
         return CLS_ZERO;
      else if (v[FRAC_W +: EXP_W] == '1)
         return (v[FRAC_W-1:0] == '0) ? CLS_INF : CLS_NAN;
      else
         return CLS_NORMAL;
   endfunction
endpackage

// File: rtl/fpmu_shift_add_mul.sv
// rtl/fpmu_shift_add_mul.sv - iterative W x W shift-add mantissa multiplier, one bit per cycle.
module fpmu_shift_add_mul
   import fpmu_pkg::*;
#(
   parameter int W = MANT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic [2*W-1:0]   acc,
   output logic             done
);
   localparam int IW = $clog2(W);
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   logic [W-1:0]  ma;
   logic [W-1:0]  mb;
   logic [IW-1:0] iter;
   logic          running;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ma      <= '0;
         mb      <= '0;
         acc     <= '0;
         iter    <= '0;
         running <= 1'b0;
      end else if (start) begin
         ma      <= a;
         mb      <= b;
         acc     <= '0;
         iter    <= '0;
         running <= 1'b1;
      end else if (running) begin
         if (mb[iter])
            acc <= acc + ({{W{1'b0}}, ma} << iter);
         if (iter == LAST)
            running <= 1'b0;
         else
            iter <= iter + 1'b1;
      end
   end

   // High during the final accumulate cycle; acc is complete on the following cycle.
   assign done = running && (iter == LAST);
endmodule

// File: rtl/fpmu_seq_ctrl.sv
// rtl/fpmu_seq_ctrl.sv - byte-serial FP16 multiply sequencer: load, classify, multiply, pack, return.
module fpmu_seq_ctrl
   import fpmu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       ovf,
   output logic       unf
);
   state_t          state;
   state_t          state_next;
   logic [1:0]      byte_cnt;
   logic [31:0]     ops;
   logic [15:0]     result;

   logic [15:0]     op_a;
   logic [15:0]     op_b;
   op_class_t       cls_a;
   op_class_t       cls_b;
   logic            sign;
   logic            accept;
   logic            last_byte;
   logic            special;
   logic [15:0]     special_res;
   logic            mul_start;
   logic            mul_done;
   logic [ACC_W-1:0] acc;

   logic signed [6:0] e_raw;
   logic signed [6:0] e_adj;
   logic [FRAC_W-1:0] frac;
   logic [15:0]     norm_res;
   logic            norm_ovf;
   logic            norm_unf;

   assign op_a = ops[31:16];
   assign op_b = ops[15:0];
   assign cls_a = classify(op_a);
   assign cls_b = classify(op_b);
   assign sign = op_a[15] ^ op_b[15];

   assign in_ready  = (state == ST_LOAD);
   assign busy      = (state != ST_LOAD);
   assign out_valid = (state == ST_OUT_HI) || (state == ST_OUT_LO);
   assign accept    = in_ready && in_valid;
   assign last_byte = accept && (byte_cnt == 2'd3);

   fpmu_shift_add_mul #(.W(MANT_W)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     ({1'b1, op_a[FRAC_W-1:0]}),
      .b     ({1'b1, op_b[FRAC_W-1:0]}),
      .acc   (acc),
      .done  (mul_done)
   );

   always_comb begin
      special     = 1'b1;
      special_res = FP16_QNAN;
      if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
          (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
          (cls_a == CLS_ZERO && cls_b == CLS_INF))
         special_res = FP16_QNAN;
      else if ((cls_a == CLS_INF) || (cls_b == CLS_INF))
         special_res = {sign, FP16_INF[14:0]};
      else if ((cls_a == CLS_ZERO) || (cls_b == CLS_ZERO))
         special_res = {sign, 15'd0};
      else
         special = 1'b0;
   end

   // Product of two [1,2) mantissas lies in [1,4); acc[21] selects the extra binade.
   always_comb begin
      e_raw = 7'({2'b00, op_a[FRAC_W +: EXP_W]}) + 7'({2'b00, op_b[FRAC_W +: EXP_W]}) - 7'(BIAS);
      e_adj = acc[ACC_W-1] ? e_raw + 7'sd1 : e_raw;
      frac  = acc[ACC_W-1] ? acc[ACC_W-2 -: FRAC_W] : acc[ACC_W-3 -: FRAC_W];
      norm_ovf = 1'b0;
      norm_unf = 1'b0;
      norm_res = {sign, e_adj[EXP_W-1:0], frac};
      if (e_adj >= 7'sd31) begin
         norm_ovf = 1'b1;
         norm_res = {sign, FP16_INF[14:0]};
      end else if (e_adj <= 7'sd0) begin
         norm_unf = 1'b1;
         norm_res = {sign, 15'd0};
      end
   end

   always_comb begin
      state_next = state;
      mul_start  = 1'b0;
      out_data   = 8'h00;
      case (state)
         ST_LOAD:   if (last_byte) state_next = ST_CHECK;
         ST_CHECK: begin
            if (special) begin
               state_next = ST_OUT_HI;
            end else begin
               state_next = ST_MUL;
               mul_start  = 1'b1;
            end
         end
         ST_MUL:    if (mul_done) state_next = ST_NORM;
         ST_NORM:   state_next = ST_OUT_HI;
         ST_OUT_HI: begin
            out_data = result[15:8];
            if (out_ready) state_next = ST_OUT_LO;
         end
         ST_OUT_LO: begin
            out_data = result[7:0];
            if (out_ready) state_next = ST_LOAD;
         end
         default:   state_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_LOAD;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= 2'd0;
         ops      <= '0;
         result   <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
      end else begin
         if (accept) begin
            ops      <= {ops[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (last_byte) begin
            ovf <= 1'b0;
            unf <= 1'b0;
         end
         if (state == ST_CHECK && special)
            result <= special_res;
         if (state == ST_NORM) begin
            result <= norm_res;
            ovf    <= norm_ovf;
            unf    <= norm_unf;
         end
      end
   end
endmodule

// File: tb/tb_fpmu_seq_ctrl.sv
// tb/tb_fpmu_seq_ctrl.sv - directed table-driven bench for fpmu_seq_ctrl.
module tb_fpmu_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       ovf;
   logic       unf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   fpmu_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .ovf       (ovf),
      .unf       (unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic load_op(input logic [15:0] a, input logic [15:0] b);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(b[15:8]);
      send_byte(b[7:0]);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      out_ready = 1'b1;
      load_op(v.a, v.b);
      wait_valid(lat);
      check({tag, "_latency"}, 32'(lat), 32'(v.lat));
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hi"}, 32'(out_data), 32'(v.res[15:8]));
      check({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
      check({tag, "_unf"}, 32'(unf), 32'(v.unf));
      @(posedge clk); #1;
      check({tag, "_lo"}, 32'(out_data), 32'(v.res[7:0]));
      @(posedge clk); #1;
      check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_ovf_hold"}, 32'(ovf), 32'(v.ovf));
      check({tag, "_unf_hold"}, 32'(unf), 32'(v.unf));
   endtask

   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      vecs[0] = '{16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0, 13};
      vecs[1] = '{16'h4000, 16'h4200, 16'h4600, 1'b0, 1'b0, 13};
      vecs[2] = '{16'h3E00, 16'h3E00, 16'h4080, 1'b0, 1'b0, 13};
      vecs[3] = '{16'hC000, 16'h4000, 16'hC400, 1'b0, 1'b0, 13};
      vecs[4] = '{16'h3C01, 16'h3C01, 16'h3C02, 1'b0, 1'b0, 13};
      vecs[5] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0, 13};
      vecs[6] = '{16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1, 13};
      vecs[7] = '{16'h7C00, 16'h0000, 16'h7E00, 1'b0, 1'b0, 1};

      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_unf", 32'(unf), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-pressure in OUT_HI with stray input bytes that must be ignored.
      out_ready = 1'b0;
      load_op(16'h4000, 16'h4200);
      wait_valid(lat);
      check("hold_latency", 32'(lat), 32'd13);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hA5 + 8'(i);
         @(posedge clk); #1;
         check($sformatf("hold_data%0d", i), 32'(out_data), 32'h46);
         check($sformatf("hold_valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("hold_in_ready%0d", i), 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_lo", 32'(out_data), 32'h00);
      @(posedge clk); #1;
      check("hold_in_ready_back", 32'(in_ready), 32'd1);
      run_vec(vecs[0], "after_hold");

      // Reset mid-multiply, then reset after a partial load.
      load_op(16'h3C00, 16'h3E00);
      repeat (4) @(posedge clk);
      #1;
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
      pulse_reset("rst_mul");
      send_byte(8'h3E);
      send_byte(8'h00);
      pulse_reset("rst_partial");
      run_vec(vecs[1], "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
